// File: rtl/stage_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   ADDR_W / INST_W : default address and instruction widths
//   INST_BYTES      : fetch stride in bytes
//   fetch_state_e   : fetch FSM state encoding
package stage_if_fetch_pkg;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,    // nothing outstanding
        StReq,     // request valid, not yet accepted
        StWait,    // accepted, awaiting response
        StSquash,  // accepted, response will be discarded
        StHalt     // stopped after a misaligned redirect
    } fetch_state_e;

endpackage

// File: rtl/stage_if_fetch_if.sv
// Instruction-memory read channel between fetch stage and memory.
//   imem_req_valid/ready/addr : request handshake (master drives valid/addr)
//   imem_resp_valid/data      : read data returned by memory
// Modports: master = fetch stage, slave = instruction memory.
interface stage_if_fetch_if #(
    parameter int unsigned ADDR_WIDTH = stage_if_fetch_pkg::ADDR_W,
    parameter int unsigned INST_WIDTH = stage_if_fetch_pkg::INST_W
) ();

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/stage_if_fetch_pc_gen.sv
// Fetch PC generator: holds the architectural fetch PC, advances it by one
// instruction on request acceptance, and loads redirect targets.
//   i_clk, i_reset          : clock, synchronous active-low reset
//   i_redirect_valid/addr   : redirect pulse and target (wins over advance)
//   i_advance               : request accepted this cycle
//   o_fetch_pc              : current fetch PC
//   o_misaligned            : redirect target not instruction-aligned
module stage_if_fetch_pc_gen #(
    parameter int unsigned           ADDR_WIDTH = stage_if_fetch_pkg::ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_fetch_pc,
    output logic                  o_misaligned
);

    import stage_if_fetch_pkg::*;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (i_redirect_valid) begin
            w_fetch_pc_next = i_redirect_addr;
        end else if (i_advance) begin
            // Natural wrap at 2^ADDR_WIDTH.
            w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(INST_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fetch_pc <= RESET_PC;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    assign o_fetch_pc   = r_fetch_pc;
    assign o_misaligned = i_redirect_valid & (i_redirect_addr[1:0] != 2'b00);

endmodule

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: one outstanding imem read at a time, combinational
// delivery of returned instructions, redirect/squash handling and fault halt.
//   i_clk, i_reset        : clock, synchronous active-low reset
//   i_stall               : hazard-unit stall
//   i_if_buffer_stall     : IF/ID buffer full
//   i_redirect_valid/addr : one-cycle redirect from decode
//   imem                  : instruction-memory channel (master side)
//   o_pc, o_inst          : delivered instruction and its PC (zero when invalid)
//   o_inst_valid          : delivery strobe
//   o_fetch_fault         : one-cycle pulse after a misaligned redirect
module stage_if_fetch #(
    parameter int unsigned           ADDR_WIDTH = stage_if_fetch_pkg::ADDR_W,
    parameter int unsigned           INST_WIDTH = stage_if_fetch_pkg::INST_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_if_buffer_stall,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    stage_if_fetch_if.master      imem,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_inst_valid,
    output logic                  o_fetch_fault
);

    import stage_if_fetch_pkg::*;

    fetch_state_e          r_state;
    fetch_state_e          w_state_d;
    fetch_state_e          w_rest;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic                  r_halt_pend;
    logic                  r_fault;

    logic [ADDR_WIDTH-1:0] w_fetch_pc;
    logic                  w_mis;
    logic                  w_hold;
    logic                  w_req_valid;
    logic                  w_accept;
    logic                  w_deliver;

    stage_if_fetch_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_addr  (i_redirect_addr),
        .i_advance        (w_accept),
        .o_fetch_pc       (w_fetch_pc),
        .o_misaligned     (w_mis)
    );

    always_comb begin
        w_hold      = i_stall | i_if_buffer_stall;
        // Where the FSM lands after a redirect once nothing is outstanding.
        w_rest      = w_mis ? StHalt : StIdle;
        w_req_valid = 1'b0;
        w_deliver   = 1'b0;
        w_state_d   = r_state;

        // Request/delivery outputs. A redirect suppresses any new issue so the
        // stale fetch_pc is never sent; an in-flight REQ is still held.
        unique case (r_state)
            StIdle: w_req_valid = i_reset & ~w_hold & ~i_redirect_valid;
            StReq:  w_req_valid = i_reset;
            StWait: begin
                if (imem.imem_resp_valid) begin
                    w_deliver   = i_reset & ~i_redirect_valid;
                    w_req_valid = i_reset & ~w_hold & ~i_redirect_valid;
                end
            end
            default: ;
        endcase

        w_accept = w_req_valid & imem.imem_req_ready;

        unique case (r_state)
            StIdle, StReq: begin
                if (i_redirect_valid) begin
                    w_state_d = w_accept ? StSquash : w_rest;
                end else if (w_accept) begin
                    w_state_d = StWait;
                end else if (w_req_valid) begin
                    w_state_d = StReq;
                end
            end
            StWait: begin
                if (imem.imem_resp_valid) begin
                    // Response consumed this cycle (delivered or dropped).
                    if (i_redirect_valid) begin
                        w_state_d = w_rest;
                    end else if (w_accept) begin
                        w_state_d = StWait;
                    end else if (w_req_valid) begin
                        w_state_d = StReq;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (i_redirect_valid) begin
                    w_state_d = StSquash;
                end
            end
            StSquash: begin
                if (imem.imem_resp_valid) begin
                    if (i_redirect_valid) begin
                        w_state_d = w_rest;
                    end else begin
                        w_state_d = r_halt_pend ? StHalt : StIdle;
                    end
                end
            end
            StHalt: begin
                if (i_redirect_valid) begin
                    w_state_d = w_rest;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_req_pc    <= '0;
            r_halt_pend <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_req_pc <= w_fetch_pc;
            end
            // Latest redirect decides whether a pending squash ends in HALT.
            if (i_redirect_valid) begin
                r_halt_pend <= w_mis;
            end
            r_fault <= w_mis;
        end
    end

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = w_fetch_pc;
    assign o_inst_valid        = w_deliver;
    assign o_pc                = w_deliver ? r_req_pc : '0;
    assign o_inst              = w_deliver ? imem.imem_resp_data : '0;
    assign o_fetch_fault       = r_fault;

endmodule

// File: tb/tb_stage_if_fetch.sv
// Directed, table-driven bench for stage_if_fetch. Each record is one clock
// cycle: inputs are driven after the falling edge, outputs compared 1 ns later.
module tb_stage_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        bstall;
    logic        redir_v;
    logic [63:0] redir_a;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;

    int checks;
    int failures;

    stage_if_fetch_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) imem_bus ();

    stage_if_fetch #(
        .ADDR_WIDTH (64),
        .INST_WIDTH (32),
        .RESET_PC   (64'h0)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_stall           (stall),
        .i_if_buffer_stall (bstall),
        .i_redirect_valid  (redir_v),
        .i_redirect_addr   (redir_a),
        .imem              (imem_bus),
        .o_pc              (pc),
        .o_inst            (inst),
        .o_inst_valid      (inst_valid),
        .o_fetch_fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic        bs;
        logic        rv;
        logic [63:0] ra;
        logic        rdy;
        logic        rspv;
        logic [31:0] rd;
        logic        ereqv;
        logic [63:0] eaddr;
        logic        eiv;
        logic [63:0] epc;
        logic [31:0] einst;
        logic        efault;
    } vec_t;

    vec_t vecs[$];

    // Memory contents: distinct word per address.
    function automatic logic [31:0] mem(input logic [63:0] a);
        return 32'h1300_0000 + a[31:0];
    endfunction

    function automatic vec_t mk(input string name, input int rst, input int st, input int bs,
                                input int rv, input logic [63:0] ra, input int rdy,
                                input int rspv, input logic [31:0] rd, input int ereqv,
                                input logic [63:0] eaddr, input int eiv,
                                input logic [63:0] epc, input logic [31:0] einst,
                                input int efault);
        vec_t v;
        v.name   = name;
        v.rst    = rst[0];
        v.st     = st[0];
        v.bs     = bs[0];
        v.rv     = rv[0];
        v.ra     = ra;
        v.rdy    = rdy[0];
        v.rspv   = rspv[0];
        v.rd     = rd;
        v.ereqv  = ereqv[0];
        v.eaddr  = eaddr;
        v.eiv    = eiv[0];
        v.epc    = epc;
        v.einst  = einst;
        v.efault = efault[0];
        return v;
    endfunction

    // Drive one cycle, compare, advance to the next falling edge.
    // Address is compared only while a request is expected, or when forced.
    task automatic apply(input vec_t v, input bit force_addr);
        logic bad;
        rst_n                    = v.rst;
        stall                    = v.st;
        bstall                   = v.bs;
        redir_v                  = v.rv;
        redir_a                  = v.ra;
        imem_bus.imem_req_ready  = v.rdy;
        imem_bus.imem_resp_valid = v.rspv;
        imem_bus.imem_resp_data  = v.rd;
        #1;
        checks++;
        bad = (imem_bus.imem_req_valid !== v.ereqv) ||
              ((v.ereqv || force_addr) && (imem_bus.imem_req_addr !== v.eaddr)) ||
              (inst_valid !== v.eiv) || (pc !== v.epc) || (inst !== v.einst) ||
              (fault !== v.efault);
        if (bad) begin
            failures++;
            $display("FAIL %s: got req_v=%0b addr=%h iv=%0b pc=%h inst=%h fault=%0b ; want req_v=%0b addr=%h iv=%0b pc=%h inst=%h fault=%0b",
                     v.name, imem_bus.imem_req_valid, imem_bus.imem_req_addr, inst_valid, pc,
                     inst, fault, v.ereqv, v.eaddr, v.eiv, v.epc, v.einst, v.efault);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        bstall   = 1'b0;
        redir_v  = 1'b0;
        redir_a  = '0;
        imem_bus.imem_req_ready  = 1'b0;
        imem_bus.imem_resp_valid = 1'b0;
        imem_bus.imem_resp_data  = '0;
        @(negedge clk);

        // Reset state, with stall low to show no request escapes during reset.
        apply(mk("reset", 0,0,0,0,64'h0, 1,0,32'h0, 0,64'h0, 0,64'h0,32'h0, 0), 1'b1);

        //      name            rst st bs rv ra                      rdy rv  rd
        //                      ereqv eaddr                  eiv epc               einst      fault
        vecs.push_back(mk("seq_req0",     1,0,0,0,64'h0, 1,0,32'h0,        1,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("seq_dlv0",     1,0,0,0,64'h0, 1,1,mem(64'h0),   1,64'h4,  1,64'h0,mem(64'h0),0));
        vecs.push_back(mk("seq_dlv4",     1,0,0,0,64'h0, 1,1,mem(64'h4),   1,64'h8,  1,64'h4,mem(64'h4),0));
        vecs.push_back(mk("seq_dlv8",     1,0,0,0,64'h0, 1,1,mem(64'h8),   1,64'hC,  1,64'h8,mem(64'h8),0));
        vecs.push_back(mk("rdy_lo_1",     1,0,0,0,64'h0, 0,1,mem(64'hC),   1,64'h10, 1,64'hC,mem(64'hC),0));
        vecs.push_back(mk("rdy_lo_2",     1,0,0,0,64'h0, 0,0,32'h0,        1,64'h10, 0,64'h0,0,0));
        vecs.push_back(mk("rdy_lo_hold",  1,1,0,0,64'h0, 0,0,32'h0,        1,64'h10, 0,64'h0,0,0));
        vecs.push_back(mk("rdy_accept",   1,0,0,0,64'h0, 1,0,32'h0,        1,64'h10, 0,64'h0,0,0));
        vecs.push_back(mk("dlv_10",       1,0,0,0,64'h0, 1,1,mem(64'h10),  1,64'h14, 1,64'h10,mem(64'h10),0));
        vecs.push_back(mk("stall_wait",   1,1,0,0,64'h0, 1,0,32'h0,        0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("stall_dlv",    1,1,0,0,64'h0, 1,1,mem(64'h14),  0,64'h0,  1,64'h14,mem(64'h14),0));
        vecs.push_back(mk("stall_idle",   1,1,0,0,64'h0, 1,0,32'h0,        0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("bstall_idle",  1,0,1,0,64'h0, 1,0,32'h0,        0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("resume_18",    1,0,0,0,64'h0, 1,0,32'h0,        1,64'h18, 0,64'h0,0,0));
        vecs.push_back(mk("dlv_18",       1,0,0,0,64'h0, 1,1,mem(64'h18),  1,64'h1C, 1,64'h18,mem(64'h18),0));
        vecs.push_back(mk("dlv_1c",       1,0,0,0,64'h0, 1,1,mem(64'h1C),  1,64'h20, 1,64'h1C,mem(64'h1C),0));
        vecs.push_back(mk("redir_wait",   1,0,0,1,64'h200, 1,0,32'h0,      0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("squash_drop",  1,0,0,0,64'h0, 1,1,mem(64'h20),  0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("redir_req",    1,0,0,0,64'h0, 1,0,32'h0,        1,64'h200,0,64'h0,0,0));
        vecs.push_back(mk("dlv_200",      1,0,0,0,64'h0, 0,1,mem(64'h200), 1,64'h204,1,64'h200,mem(64'h200),0));
        vecs.push_back(mk("mis_redir",    1,0,0,1,64'h102, 0,0,32'h0,      1,64'h204,0,64'h0,0,0));
        vecs.push_back(mk("fault_pulse",  1,0,0,0,64'h0, 1,1,mem(64'h104), 0,64'h0,  0,64'h0,0,1));
        vecs.push_back(mk("halt_quiet",   1,0,0,0,64'h0, 1,0,32'h0,        0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("halt_exit",    1,0,0,1,64'h100, 1,0,32'h0,      0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("req_100",      1,0,0,0,64'h0, 1,0,32'h0,        1,64'h100,0,64'h0,0,0));
        vecs.push_back(mk("dlv_100",      1,0,0,0,64'h0, 1,1,mem(64'h100), 1,64'h104,1,64'h100,mem(64'h100),0));
        vecs.push_back(mk("mis_wait",     1,0,0,1,64'h301, 1,0,32'h0,      0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("mis_drain",    1,0,0,0,64'h0, 1,1,mem(64'h104), 0,64'h0,  0,64'h0,0,1));
        vecs.push_back(mk("halt2",        1,0,0,0,64'h0, 1,0,32'h0,        0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("redir_top",    1,0,0,1,64'hFFFF_FFFF_FFFF_FFF8, 1,0,32'h0, 0,64'h0, 0,64'h0,0,0));
        vecs.push_back(mk("req_fff8",     1,0,0,0,64'h0, 1,0,32'h0,
                          1,64'hFFFF_FFFF_FFFF_FFF8, 0,64'h0,0,0));
        vecs.push_back(mk("dlv_fff8",     1,0,0,0,64'h0, 1,1,mem(64'hFFFF_FFFF_FFFF_FFF8),
                          1,64'hFFFF_FFFF_FFFF_FFFC, 1,64'hFFFF_FFFF_FFFF_FFF8,
                          mem(64'hFFFF_FFFF_FFFF_FFF8),0));
        vecs.push_back(mk("wrap_req0",    1,0,0,0,64'h0, 1,1,mem(64'hFFFF_FFFF_FFFF_FFFC),
                          1,64'h0, 1,64'hFFFF_FFFF_FFFF_FFFC, mem(64'hFFFF_FFFF_FFFF_FFFC),0));
        vecs.push_back(mk("dlv_wrap0",    1,0,0,0,64'h0, 0,1,mem(64'h0),   1,64'h4,  1,64'h0,mem(64'h0),0));
        vecs.push_back(mk("redir_acc",    1,0,0,1,64'h400, 1,0,32'h0,      1,64'h4,  0,64'h0,0,0));
        vecs.push_back(mk("squash_acc",   1,0,0,0,64'h0, 1,1,mem(64'h4),   0,64'h0,  0,64'h0,0,0));
        vecs.push_back(mk("req_400",      1,0,0,0,64'h0, 1,0,32'h0,        1,64'h400,0,64'h0,0,0));
        vecs.push_back(mk("redir_resp",   1,0,0,1,64'h500, 1,1,mem(64'h400), 0,64'h0, 0,64'h0,0,0));
        vecs.push_back(mk("req_500",      1,0,0,0,64'h0, 1,0,32'h0,        1,64'h500,0,64'h0,0,0));
        vecs.push_back(mk("dlv_500_stl",  1,1,0,0,64'h0, 1,1,mem(64'h500), 0,64'h0,  1,64'h500,mem(64'h500),0));
        vecs.push_back(mk("req_504",      1,0,0,0,64'h0, 1,0,32'h0,        1,64'h504,0,64'h0,0,0));

        foreach (vecs[i]) begin
            apply(vecs[i], 1'b0);
        end

        // Reset while 0x504 is outstanding: its response must never surface,
        // and the stale response after reset is ignored.
        apply(mk("rst_mid",   0,0,0,0,64'h0, 1,1,mem(64'h504), 0,64'h0, 0,64'h0,0,0), 1'b0);
        apply(mk("rst_stale", 1,0,0,0,64'h0, 0,1,mem(64'h504), 1,64'h0, 0,64'h0,0,0), 1'b0);
        apply(mk("rst_acc",   1,0,0,0,64'h0, 1,0,32'h0,        1,64'h0, 0,64'h0,0,0), 1'b0);
        apply(mk("rst_dlv",   1,0,0,0,64'h0, 1,1,mem(64'h0),   1,64'h4, 1,64'h0,mem(64'h0),0),
              1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
